// File: rtl/rtc_time_reader_if.sv
// Multiplexed RTC address/data bus between the time reader (master) and the pad/RTC side (slave).
`default_nettype none

interface rtc_time_reader_if;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_a_d;
  logic [7:0] rtc_ad_out;
  logic       rtc_ad_oe;
  logic [7:0] rtc_ad_in;

  modport master (
    output rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_ad_out, rtc_ad_oe,
    input  rtc_ad_in
  );

  modport slave (
    input  rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_ad_out, rtc_ad_oe,
    output rtc_ad_in
  );
endinterface

`default_nettype wire

// File: rtl/rtc_time_reader.sv
// Sweeps nine RTC time/date/timer registers over a multiplexed bus and publishes them as BCD digits.
// Optional periodic auto-refresh is enabled by defining RTC_AUTO_REFRESH_EN.
`default_nettype none

module rtc_time_reader #(
  parameter int PHASE_CYC   = 10,
  parameter int REFRESH_CYC = 10000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              formato_hora,
  rtc_time_reader_if.master bus,
  output logic [3:0]        digit0_SS,
  output logic [3:0]        digit1_SS,
  output logic [3:0]        digit0_MM,
  output logic [3:0]        digit1_MM,
  output logic [3:0]        digit0_HH,
  output logic [3:0]        digit1_HH,
  output logic [3:0]        digit0_DAY,
  output logic [3:0]        digit1_DAY,
  output logic [3:0]        digit0_MES,
  output logic [3:0]        digit1_MES,
  output logic [3:0]        digit0_YEAR,
  output logic [3:0]        digit1_YEAR,
  output logic [3:0]        digit0_SS_T,
  output logic [3:0]        digit1_SS_T,
  output logic [3:0]        digit0_MM_T,
  output logic [3:0]        digit1_MM_T,
  output logic [3:0]        digit0_HH_T,
  output logic [3:0]        digit1_HH_T,
  output logic              AM_PM,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_AGAP  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RECOV = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int         NREG     = 9;
  localparam int         IX_HH    = 2;
  localparam int         IX_HH_T  = 8;
  localparam logic [7:0] PH_LAST  = 8'(PHASE_CYC - 1);
  localparam logic [3:0] IDX_LAST = 4'(NREG - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] shadow_q [NREG];
  logic [3:0] dig0_q   [NREG];
  logic [3:0] dig1_q   [NREG];
  logic       ampm_q;
  logic       busy_q;
  logic       done_q;
  logic       start_any;
  logic       accept;
  logic       phase_end;

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h41;
      4'd7:    reg_addr = 8'h42;
      default: reg_addr = 8'h43;
    endcase
  endfunction

  // Hour registers carry the AM/PM flag in bit 5 when the RTC runs in 12 h mode.
  function automatic logic [3:0] tens_digit(input logic [7:0] b, input logic is_hour,
                                             input logic fmt12);
    if (!is_hour)
      tens_digit = {1'b0, b[6:4]};
    else if (fmt12)
      tens_digit = {3'b000, b[4]};
    else
      tens_digit = {2'b00, b[5:4]};
  endfunction

`ifdef RTC_AUTO_REFRESH_EN
  localparam int            RW     = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_CYC - 1);

  logic [RW-1:0] refr_q;
  logic          auto_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      refr_q <= '0;
    else if (refr_q == R_LAST)
      refr_q <= '0;
    else
      refr_q <= refr_q + RW'(1);
  end

  assign auto_start = (refr_q == R_LAST);
  assign start_any  = start | auto_start;
`else
  localparam int unused_refresh_cyc = REFRESH_CYC;
  assign start_any = start;
`endif

  // A request is only honoured when idle and the previous done cycle has retired.
  assign accept    = start_any && (state_q == S_IDLE) && !busy_q;
  assign phase_end = (phase_q == PH_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ADDR;
          phase_d = '0;
          idx_d   = '0;
        end
      end
      S_ADDR: begin
        phase_d = phase_end ? 8'd0 : phase_q + 8'd1;
        if (phase_end) state_d = S_AGAP;
      end
      S_AGAP: begin
        phase_d = phase_end ? 8'd0 : phase_q + 8'd1;
        if (phase_end) state_d = S_READ;
      end
      S_READ: begin
        phase_d = phase_end ? 8'd0 : phase_q + 8'd1;
        if (phase_end) state_d = S_RECOV;
      end
      S_RECOV: begin
        phase_d = phase_end ? 8'd0 : phase_q + 8'd1;
        if (phase_end) begin
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else if ((state_q == S_READ) && phase_end) begin
      shadow_q[idx_q] <= bus.rtc_ad_in;
    end
  end

  // Visible outputs change only in the done cycle, so a sweep is never seen half-read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        dig0_q[i] <= '0;
        dig1_q[i] <= '0;
      end
      ampm_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (accept)
        busy_q <= 1'b1;
      else if (done_q)
        busy_q <= 1'b0;
      if (state_q == S_DONE) begin
        for (int i = 0; i < NREG; i++) begin
          dig0_q[i] <= shadow_q[i][3:0];
          dig1_q[i] <= tens_digit(shadow_q[i], (i == IX_HH) || (i == IX_HH_T), formato_hora);
        end
        ampm_q <= formato_hora & shadow_q[IX_HH][5];
      end
    end
  end

  always_comb begin
    bus.rtc_cs_n   = 1'b1;
    bus.rtc_rd_n   = 1'b1;
    bus.rtc_wr_n   = 1'b1;
    bus.rtc_a_d    = 1'b0;
    bus.rtc_ad_oe  = 1'b0;
    bus.rtc_ad_out = 8'h00;
    case (state_q)
      S_ADDR: begin
        bus.rtc_cs_n   = 1'b0;
        bus.rtc_wr_n   = 1'b0;
        bus.rtc_ad_oe  = 1'b1;
        bus.rtc_ad_out = reg_addr(idx_q);
      end
      S_AGAP: begin
        bus.rtc_ad_oe  = 1'b1;
        bus.rtc_ad_out = reg_addr(idx_q);
      end
      S_READ: begin
        bus.rtc_cs_n = 1'b0;
        bus.rtc_rd_n = 1'b0;
        bus.rtc_a_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign digit0_SS   = dig0_q[0];
  assign digit1_SS   = dig1_q[0];
  assign digit0_MM   = dig0_q[1];
  assign digit1_MM   = dig1_q[1];
  assign digit0_HH   = dig0_q[2];
  assign digit1_HH   = dig1_q[2];
  assign digit0_DAY  = dig0_q[3];
  assign digit1_DAY  = dig1_q[3];
  assign digit0_MES  = dig0_q[4];
  assign digit1_MES  = dig1_q[4];
  assign digit0_YEAR = dig0_q[5];
  assign digit1_YEAR = dig1_q[5];
  assign digit0_SS_T = dig0_q[6];
  assign digit1_SS_T = dig1_q[6];
  assign digit0_MM_T = dig0_q[7];
  assign digit1_MM_T = dig1_q[7];
  assign digit0_HH_T = dig0_q[8];
  assign digit1_HH_T = dig1_q[8];
  assign AM_PM       = ampm_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_time_reader.sv
// Bench for rtc_time_reader: behavioural RTC on the bus plus an arithmetic model of the digit decode.
module tb_rtc_time_reader;
  localparam int P   = 4;
  localparam int LAT = 36 * P + 2;
`ifdef RTC_AUTO_REFRESH_EN
  localparam int RCYC = 400;
`else
  localparam int RCYC = 10000000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic fmt = 1'b0;
  logic [3:0] d0_ss, d1_ss, d0_mm, d1_mm, d0_hh, d1_hh, d0_day, d1_day, d0_mes, d1_mes;
  logic [3:0] d0_yr, d1_yr, d0_sst, d1_sst, d0_mmt, d1_mmt, d0_hht, d1_hht;
  logic am_pm, busy, done;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [256];
  logic [7:0] addrs [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] lat_addr = 8'h00;
  logic [7:0] addr_log [$];
  int         viol = 0;
  int         nreads = 0;
  logic       wr_prev = 1'b0;
  logic       rd_prev = 1'b0;

  rtc_time_reader_if bus ();

  always #5 clk = ~clk;

  rtc_time_reader #(.PHASE_CYC(P), .REFRESH_CYC(RCYC)) dut (
    .clock(clk), .reset(rst_n), .start(start), .formato_hora(fmt), .bus(bus),
    .digit0_SS(d0_ss), .digit1_SS(d1_ss), .digit0_MM(d0_mm), .digit1_MM(d1_mm),
    .digit0_HH(d0_hh), .digit1_HH(d1_hh), .digit0_DAY(d0_day), .digit1_DAY(d1_day),
    .digit0_MES(d0_mes), .digit1_MES(d1_mes), .digit0_YEAR(d0_yr), .digit1_YEAR(d1_yr),
    .digit0_SS_T(d0_sst), .digit1_SS_T(d1_sst), .digit0_MM_T(d0_mmt), .digit1_MM_T(d1_mmt),
    .digit0_HH_T(d0_hht), .digit1_HH_T(d1_hht), .AM_PM(am_pm), .busy(busy), .done(done)
  );

  // RTC side: latch the address while write-strobed, return the register while read-strobed.
  assign bus.rtc_ad_in = (!bus.rtc_cs_n && !bus.rtc_rd_n && bus.rtc_a_d) ? mem[lat_addr] : 8'h00;

  always @(posedge clk)
    if (!bus.rtc_cs_n && !bus.rtc_wr_n && !bus.rtc_a_d) lat_addr <= bus.rtc_ad_out;

  always @(negedge clk) begin
    if ((!bus.rtc_rd_n && !bus.rtc_wr_n) || (!bus.rtc_rd_n && bus.rtc_ad_oe)) viol <= viol + 1;
    if (!bus.rtc_wr_n && !bus.rtc_cs_n && !wr_prev) addr_log.push_back(bus.rtc_ad_out);
    if (!bus.rtc_rd_n && !bus.rtc_cs_n && !rd_prev) nreads <= nreads + 1;
    wr_prev <= !bus.rtc_wr_n && !bus.rtc_cs_n;
    rd_prev <= !bus.rtc_rd_n && !bus.rtc_cs_n;
  end

  function automatic logic [72:0] dut_vec();
    return {am_pm, d1_ss, d0_ss, d1_mm, d0_mm, d1_hh, d0_hh, d1_day, d0_day, d1_mes, d0_mes,
            d1_yr, d0_yr, d1_sst, d0_sst, d1_mmt, d0_mmt, d1_hht, d0_hht};
  endfunction

  function automatic logic [72:0] model_vec(input logic f12);
    logic [72:0] v;
    int b, tens;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      b = int'(mem[addrs[i]]);
      if (i == 2 || i == 8) tens = f12 ? (b / 16) % 2 : (b / 16) % 4;
      else                  tens = (b / 16) % 8;
      v[71-8*i -: 8] = {4'(tens), 4'(b % 16)};
    end
    v[72] = f12 && (((int'(mem[8'h23]) / 32) % 2) == 1);
    return v;
  endfunction

  task automatic run_sweep(input bit in_place, input int extra_at, output int lat, output int nd,
                           output int berr, output int perr, output logic [72:0] vfirst);
    logic [72:0] vprev;
    lat = -1; nd = 0; berr = 0; perr = 0; vfirst = '0; vprev = '0;
    if (!in_place) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    for (int n = 1; n <= 2 * LAT + 10; n++) begin
      @(negedge clk);
      start = (n == extra_at);
      if (n == 1) begin
        vfirst = dut_vec();
        vprev  = vfirst;
      end
      if (done) begin
        nd++;
        if (lat < 0) lat = n;
      end
      if (busy !== ((lat < 0) || (n == lat))) berr++;
      if (lat < 0 && dut_vec() !== vprev) perr++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.rtc_cs_n, bus.rtc_rd_n, bus.rtc_wr_n, bus.rtc_a_d, bus.rtc_ad_oe, bus.rtc_ad_out}
        !== {3'b111, 2'b00, 8'h00}) begin
      errors++;
      $display("FAIL reset_bus: got cs/rd/wr=%b%b%b a_d=%b oe=%b ad=%h want 111 0 0 00",
               bus.rtc_cs_n, bus.rtc_rd_n, bus.rtc_wr_n, bus.rtc_a_d, bus.rtc_ad_oe, bus.rtc_ad_out);
    end
    vectors++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_digits: got %h want 0", dut_vec());
    end
    vectors++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done: got %b want 00", {busy, done});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_24h();
    int lat, nd, berr, perr;
    logic [72:0] v0;
    logic [7:0] vals [9] = '{8'h59, 8'h47, 8'h23, 8'h31, 8'h12, 8'h16, 8'h05, 8'h10, 8'h01};
    for (int i = 0; i < 9; i++) mem[addrs[i]] = vals[i];
    fmt = 1'b0;
    run_sweep(1'b0, 0, lat, nd, berr, perr, v0);
    vectors++;
    if (lat != LAT) begin errors++; $display("FAIL latency_24h: got %0d want %0d", lat, LAT); end
    vectors++;
    if (nd != 1) begin errors++; $display("FAIL done_count_24h: got %0d want 1", nd); end
    vectors++;
    if (berr != 0) begin errors++; $display("FAIL busy_window_24h: got %0d bad cycles want 0", berr); end
    vectors++;
    if (perr != 0) begin errors++; $display("FAIL partial_update_24h: got %0d changes want 0", perr); end
    vectors++;
    if (dut_vec() !== {1'b0, 72'h594723311216051001}) begin
      errors++;
      $display("FAIL digits_24h: got %h want %h", dut_vec(), {1'b0, 72'h594723311216051001});
    end
  endtask

  task automatic test_12h();
    int lat, nd, berr, perr;
    logic [72:0] v0;
    mem[8'h23] = 8'h31;
    fmt = 1'b1;
    run_sweep(1'b0, 0, lat, nd, berr, perr, v0);
    vectors++;
    if ({d1_hh, d0_hh, am_pm} !== {4'd1, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL hour_12h: got %h/%h ampm=%b want 1/1 ampm=1", d1_hh, d0_hh, am_pm);
    end
    vectors++;
    if (dut_vec() !== model_vec(1'b1)) begin
      errors++;
      $display("FAIL digits_12h: got %h want %h", dut_vec(), model_vec(1'b1));
    end
    fmt = 1'b0;
  endtask

  task automatic test_bus();
    int lat, nd, berr, perr, base, v0cnt;
    logic [72:0] v0;
    logic [71:0] got, exp;
    base = addr_log.size();
    v0cnt = viol;
    run_sweep(1'b0, 0, lat, nd, berr, perr, v0);
    got = '0; exp = '0;
    for (int i = 0; i < 9; i++) begin
      exp[71-8*i -: 8] = addrs[i];
      if (base + i < addr_log.size()) got[71-8*i -: 8] = addr_log[base+i];
    end
    vectors++;
    if (got !== exp || addr_log.size() != base + 9) begin
      errors++;
      $display("FAIL addr_sequence: got %h (%0d addrs) want %h (9 addrs)", got, addr_log.size() - base, exp);
    end
    vectors++;
    if (viol != v0cnt) begin
      errors++;
      $display("FAIL strobe_rules: got %0d violations want 0", viol - v0cnt);
    end
  endtask

  task automatic test_start_ignored();
    int lat, nd, berr, perr;
    logic [72:0] v0;
    run_sweep(1'b0, 50, lat, nd, berr, perr, v0);
    vectors++;
    if (nd != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", nd); end
    vectors++;
    if (lat != LAT) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, LAT); end
    vectors++;
    if (berr != 0) begin errors++; $display("FAIL busy_start_busy: got %0d bad cycles want 0", berr); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, berr, perr, base, r0, waited;
    logic [72:0] v0;
    logic [71:0] got, exp;
    for (int i = 0; i < 9; i++) mem[addrs[i]] = 8'($urandom);
    r0 = nreads; waited = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (nreads < r0 + 5 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (nreads < r0 + 5) begin errors++; $display("FAIL reach_fifth_read: got %0d reads want 5", nreads - r0); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rtc_cs_n, bus.rtc_rd_n, bus.rtc_wr_n, bus.rtc_a_d, bus.rtc_ad_oe, bus.rtc_ad_out}
        !== {3'b111, 2'b00, 8'h00}) begin
      errors++;
      $display("FAIL midreset_bus: got cs/rd/wr=%b%b%b oe=%b want 111 0",
               bus.rtc_cs_n, bus.rtc_rd_n, bus.rtc_wr_n, bus.rtc_ad_oe);
    end
    vectors++;
    if ({busy, done, dut_vec()} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b digits=%h want all 0", busy, done, dut_vec());
    end
    @(negedge clk); @(negedge clk);
    base = addr_log.size();
    rst_n = 1'b1;
    start = 1'b1;
    run_sweep(1'b1, 0, lat, nd, berr, perr, v0);
    vectors++;
    if (v0 !== '0 || perr != 0) begin
      errors++;
      $display("FAIL midreset_hold_zero: got first=%h changes=%0d want 0 and 0", v0, perr);
    end
    vectors++;
    if (lat != LAT) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", lat, LAT); end
    got = '0; exp = '0;
    for (int i = 0; i < 9; i++) begin
      exp[71-8*i -: 8] = addrs[i];
      if (base + i < addr_log.size()) got[71-8*i -: 8] = addr_log[base+i];
    end
    vectors++;
    if (got !== exp || addr_log.size() != base + 9) begin
      errors++;
      $display("FAIL midreset_addr_sequence: got %h want %h", got, exp);
    end
    vectors++;
    if (dut_vec() !== model_vec(fmt)) begin
      errors++;
      $display("FAIL midreset_digits: got %h want %h", dut_vec(), model_vec(fmt));
    end
  endtask

  task automatic test_random();
    int lat, nd, berr, perr;
    logic [72:0] v0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) mem[addrs[i]] = 8'($urandom);
      fmt = 1'($urandom);
      run_sweep(1'b0, 0, lat, nd, berr, perr, v0);
      vectors++;
      if (lat != LAT) begin errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", k, lat, LAT); end
      vectors++;
      if (dut_vec() !== model_vec(fmt)) begin
        errors++;
        $display("FAIL random_digits[%0d]: got %h want %h fmt=%b", k, dut_vec(), model_vec(fmt), fmt);
      end
    end
    fmt = 1'b0;
  endtask

`ifdef RTC_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int dn [$];
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dn.push_back(n);
    end
    vectors++;
    if (dn.size() != 2) begin errors++; $display("FAIL auto_done_count: got %0d want 2", dn.size()); end
    vectors++;
    if (dn.size() < 1 || dn[0] != 400 + LAT - 1) begin
      errors++;
      $display("FAIL auto_first_done: got %0d want %0d", (dn.size() > 0) ? dn[0] : -1, 400 + LAT - 1);
    end
    vectors++;
    if (dn.size() < 2 || dn[1] != 800 + LAT - 1) begin
      errors++;
      $display("FAIL auto_second_done: got %0d want %0d", (dn.size() > 1) ? dn[1] : -1, 800 + LAT - 1);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got time %0t want finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
`ifdef RTC_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_fixed_24h();
    test_12h();
    test_bus();
    test_start_ignored();
    test_reset_mid();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
